// File: rtl/gray_mean_binarize.sv
// Binarizes a gray pixel stream against a threshold that tracks the mean of the previous frame.
// The frame mean comes from a one-bit-per-clock restoring divider running behind the video.
module gray_mean_binarize #(
  parameter int unsigned IMG_H_DISP  = 640,
  parameter int unsigned IMG_V_DISP  = 480,
  parameter int unsigned INIT_THRESH = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_gray,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic [7:0] post_img_gray,
  output logic [7:0] frame_mean,
  output logic       mean_valid,
  output logic       frame_err
);

  localparam int unsigned NPIX  = IMG_H_DISP * IMG_V_DISP;
  localparam int unsigned SUM_W = 8 + $clog2(NPIX);
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned IT_W  = $clog2(SUM_W + 1);

  localparam logic [7:0]       INIT_T  = 8'(INIT_THRESH);
  localparam logic [CNT_W-1:0] NPIX_C  = CNT_W'(NPIX);
  localparam logic [IT_W-1:0]  LAST_IT = IT_W'(SUM_W - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDiv, StUpdate} state_e;

  state_e             state_q, state_d;
  logic               vsync_q;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   dvd_q, dvd_d;
  logic [CNT_W-1:0]   dsr_q, dsr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [IT_W-1:0]    it_q, it_d;
  logic [7:0]         thresh_q, thresh_d;
  logic               mean_valid_q, mean_valid_d;
  logic               frame_err_q, frame_err_d;

  logic               vs1_q, hs1_q, cmp1_q;
  logic               vs2_q, hs2_q;
  logic [7:0]         gray2_q, gray2_d;

  logic               vs_rise, vs_fall, pix_valid;
  logic [SUM_W:0]     sum_ext;
  logic [CNT_W:0]     rem_sh, diff;
  logic               ge;
  logic [7:0]         quot_sat;

  assign vs_rise   = per_img_vsync & ~vsync_q;
  assign vs_fall   = ~per_img_vsync & vsync_q;
  assign pix_valid = per_img_vsync & per_img_href;

  // Accumulator; both sum and count saturate instead of wrapping.
  always_comb begin
    sum_ext = {1'b0, sum_q} + {{(SUM_W - 7){1'b0}}, per_img_gray};
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    if (vs_rise) begin
      sum_d = pix_valid ? SUM_W'(per_img_gray) : '0;
      cnt_d = CNT_W'(pix_valid);
    end else if (pix_valid) begin
      sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Restoring divider step. The partial remainder is always below the divisor, so the
  // sign bit of the trial subtraction is a clean "does not fit" flag.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[SUM_W-1]};
    diff     = rem_sh - {1'b0, dsr_q};
    ge       = ~diff[CNT_W];
    quot_sat = (|dvd_q[SUM_W-1:8]) ? 8'hFF : dvd_q[7:0];
  end

  always_comb begin
    state_d      = state_q;
    dvd_d        = dvd_q;
    dsr_d        = dsr_q;
    rem_d        = rem_q;
    it_d         = it_q;
    thresh_d     = thresh_q;
    mean_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      StIdle, StAccum: begin
        if (vs_rise) state_d = StAccum;
      end
      StDiv: begin
        rem_d = ge ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        dvd_d = {dvd_q[SUM_W-2:0], ge};
        it_d  = it_q + IT_W'(1);
        if (it_q == LAST_IT) state_d = StUpdate;
      end
      StUpdate: begin
        thresh_d     = quot_sat;
        mean_valid_d = 1'b1;
        state_d      = per_img_vsync ? StAccum : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A frame ending while the divider is busy is dropped; the running division is kept.
    if (vs_fall) begin
      if (state_q == StDiv) begin
        frame_err_d = 1'b1;
      end else if (cnt_q == '0) begin
        frame_err_d = 1'b1;
        state_d     = StIdle;
      end else begin
        dvd_d       = sum_q;
        dsr_d       = cnt_q;
        rem_d       = '0;
        it_d        = '0;
        frame_err_d = (cnt_q != NPIX_C);
        state_d     = StDiv;
      end
    end
  end

  assign gray2_d = (hs1_q & cmp1_q) ? 8'hFF : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b0;
      sum_q        <= '0;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dsr_q        <= '0;
      rem_q        <= '0;
      it_q         <= '0;
      thresh_q     <= INIT_T;
      mean_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      vs1_q        <= 1'b0;
      hs1_q        <= 1'b0;
      cmp1_q       <= 1'b0;
      vs2_q        <= 1'b0;
      hs2_q        <= 1'b0;
      gray2_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      vsync_q      <= per_img_vsync;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dsr_q        <= dsr_d;
      rem_q        <= rem_d;
      it_q         <= it_d;
      thresh_q     <= thresh_d;
      mean_valid_q <= mean_valid_d;
      frame_err_q  <= frame_err_d;
      vs1_q        <= per_img_vsync;
      hs1_q        <= per_img_href;
      cmp1_q       <= (per_img_gray >= thresh_q);
      vs2_q        <= vs1_q;
      hs2_q        <= hs1_q;
      gray2_q      <= gray2_d;
    end
  end

  assign post_img_vsync = vs2_q;
  assign post_img_href  = hs2_q;
  assign post_img_gray  = gray2_q;
  assign frame_mean     = thresh_q;
  assign mean_valid     = mean_valid_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_gray_mean_binarize.sv
// Directed bench for gray_mean_binarize on a 4x2 image: every cycle checks the binarized
// stream, frame_mean, mean_valid and frame_err against hand-scheduled expectations.
module tb_gray_mean_binarize;

  localparam int unsigned NPIX   = 8;
  localparam int unsigned SUM_W  = 8 + $clog2(NPIX);
  localparam int unsigned MV_LAT = SUM_W + 2;
  localparam int          NCYC   = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0, hs = 1'b0;
  logic [7:0] g = 8'h00;
  logic       post_img_vsync, post_img_href, mean_valid, frame_err;
  logic [7:0] post_img_gray, frame_mean;

  gray_mean_binarize #(
    .IMG_H_DISP (4),
    .IMG_V_DISP (2),
    .INIT_THRESH(128)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .per_img_vsync (vs),
    .per_img_href  (hs),
    .per_img_gray  (g),
    .post_img_vsync(post_img_vsync),
    .post_img_href (post_img_href),
    .post_img_gray (post_img_gray),
    .frame_mean    (frame_mean),
    .mean_valid    (mean_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         n = 0;
  logic [9:0] pipe0 = '0, pipe1 = '0;
  logic [7:0] thr = 8'd128;
  bit         mv_sched [NCYC];
  bit         err_sched[NCYC];
  logic [7:0] mv_val   [NCYC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then drive the next inputs.
  task automatic cyc(input logic v, input logic h, input logic [7:0] p);
    @(negedge clk);
    if (mv_sched[n]) thr = mv_val[n];
    chk("mean_valid", 32'(mean_valid), 32'(mv_sched[n]));
    chk("frame_err", 32'(frame_err), 32'(err_sched[n]));
    chk("frame_mean", 32'(frame_mean), 32'(thr));
    chk("post_stream", 32'({post_img_vsync, post_img_href, post_img_gray}), 32'(pipe1));
    pipe1 = pipe0;
    pipe0 = {v, h, (h && p >= thr) ? 8'hFF : 8'h00};
    vs = v;
    hs = h;
    g  = p;
    n++;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic pix(input logic [7:0] p);
    cyc(1'b1, 1'b1, p);
  endtask

  // Called right after the cycle that drove vsync low.
  task automatic end_frame(input logic [7:0] m, input bit has_mean, input bit err);
    if (has_mean) begin
      mv_sched[n - 1 + MV_LAT] = 1'b1;
      mv_val[n - 1 + MV_LAT]   = m;
    end
    if (err) err_sched[n] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      mv_sched[i]  = 1'b0;
      err_sched[i] = 1'b0;
      mv_val[i]    = 8'h00;
    end

    idle(3);
    rst_n = 1'b1;
    idle(2);

    // First frame at the initial threshold, vsync rising together with the first pixel.
    pix(127); pix(128); pix(0); pix(255); pix(10); pix(200); pix(128); pix(127);
    idle(1); end_frame(8'd121, 1, 0);
    idle(14);
    chk("mean_f1", 32'(frame_mean), 32'd121);

    // Constant 100 frame.
    cyc(1'b1, 1'b0, 8'h00);
    repeat (8) pix(100);
    idle(1); end_frame(8'd100, 1, 0);
    idle(14);
    chk("mean_const100", 32'(frame_mean), 32'd100);

    // 99/100 alternating against threshold 100.
    cyc(1'b1, 1'b0, 8'h00);
    repeat (4) begin pix(99); pix(100); end
    idle(1); end_frame(8'd99, 1, 0);
    idle(14);

    // Ramp 0..7: sum 28, count 8, truncated mean 3.
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) pix(8'(i));
    idle(1); end_frame(8'd3, 1, 0);
    idle(14);
    chk("mean_ramp", 32'(frame_mean), 32'd3);

    // Short frame of six 60s.
    cyc(1'b1, 1'b0, 8'h00);
    repeat (6) pix(60);
    idle(1); end_frame(8'd60, 1, 1);
    idle(14);

    // vsync without any href: error, threshold untouched.
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    idle(1); end_frame(8'h00, 0, 1);
    idle(14);
    chk("mean_after_empty", 32'(frame_mean), 32'd60);

    // Second frame ends while the first is still dividing: second dropped.
    cyc(1'b1, 1'b0, 8'h00);
    repeat (8) pix(200);
    idle(1); end_frame(8'd200, 1, 0);
    repeat (3) pix(50);
    idle(1); end_frame(8'h00, 0, 1);
    idle(14);
    chk("mean_overlap", 32'(frame_mean), 32'd200);

    // Reset in the middle of a division.
    cyc(1'b1, 1'b0, 8'h00);
    repeat (8) pix(10);
    idle(1); end_frame(8'd10, 1, 0);
    idle(10);
    rst_n = 1'b0;
    for (int i = n; i < NCYC; i++) begin
      mv_sched[i]  = 1'b0;
      err_sched[i] = 1'b0;
    end
    thr = 8'd128;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    chk("mean_after_reset", 32'(frame_mean), 32'd128);

    // Two-pixel frame after reset: threshold 128 again, count mismatch, mean 127.
    cyc(1'b1, 1'b0, 8'h00);
    pix(127); pix(128);
    idle(1); end_frame(8'd127, 1, 1);
    idle(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
